pulse_window_sched: RTL and testbench
=====================================

# pulse_window_sched

Measurement-window scheduler for the pulse meter inputs. It counts synchronized, debounced single-cycle pulse flags from NCH channels over back-to-back windows of programmable length. At the end of each window it latches the per-channel counts into a result bank and presents them to the host register interface through a valid/ack handshake. It sits between the per-channel debouncers and the host-readable register file on the servo board, which has a 1.8432 MHz clock.

## Interface
- NCH, 4, number of pulse channels
- CW, 16, per-channel count width in bits
- TW, 24, window-length width in bits; 2^24 cycles is about 9.1 s at 1.8432 MHz
- clk  in  1  system clock; one clock domain; all inputs are synchronous to clk
- rst  in  1  reset; synchronous, active-high
- enable  in  1  level; 1 = run windows continuously, 0 = stop
- window_len  in  TW  window length in clk cycles; 0 is treated as 1; sampled at window start
- pulse  in  NCH  per-channel single-cycle pulse flags from the debouncers
- busy  out  1  1 while in RUN
- valid  out  1  result bank holds an unread result
- rd_ack  in  1  host has consumed the result; meaningful only when valid=1
- counts  out  NCH*CW  result bank; channel i occupies bits [i*CW +: CW]
- ovf  out  NCH  per-channel saturation flag for the latched window
- overrun  out  1  a result was overwritten before it was acked
- seq  out  8  sequence number of the latched window

## Operation
- State machine states:
  - IDLE: accumulators and timer are held at 0.
  - RUN: a window is in progress.
- IDLE -> RUN when enable=1.
  - Accumulators are set to 0, and per-channel sat flags are set to 0.
  - timer <= max(window_len,1) - 1.
  - The first counted cycle is the first cycle in RUN.
- In RUN, on every cycle:
  - acc[i] <= acc[i] + pulse[i], saturating at 2^CW-1.
  - When an increment is blocked by saturation, sat[i] <= 1.
  - timer decrements by 1.
- Terminal cycle: RUN with timer==0.
  - counts[i] <= saturating acc[i] + pulse[i], so the pulse in the last cycle is included.
  - ovf[i] <= sat[i], or 1 if this final increment saturates.
  - seq <= seq + 1, wrapping 255 -> 0.
  - valid <= 1.
  - If enable=1, the next window starts with no gap: acc <= 0, sat <= 0, timer <= max(window_len,1) - 1. window_len is sampled in this cycle. State stays RUN.
  - If enable=0, go to IDLE after latching.
- enable=0 in a non-terminal RUN cycle aborts the window.
  - Go to IDLE next cycle and discard the accumulators.
  - counts, ovf, seq, valid and overrun are unchanged.
- Each window therefore spans exactly L = max(window_len,1) consecutive cycles, and consecutive windows tile time with no gaps or overlaps.
- Handshake:
  - valid=1 and rd_ack=1 in the same cycle: valid <= 0 and overrun <= 0 next cycle.
  - rd_ack while valid=0 is ignored.
  - counts, ovf and seq stay stable while valid=1, except when a new latch occurs.
- Overrun:
  - A latch while valid=1 and rd_ack=0 overwrites counts, ovf and seq, and sets overrun <= 1.
  - overrun is sticky until acked.
  - A latch in the same cycle as rd_ack (with valid=1): the ack applies to the old result and the new result is presented. Next cycle valid=1 and overrun=0.
- Width rules:
  - Accumulators are CW bits and never wrap.
  - timer is TW bits.
  - seq wraps modulo 256.

## Timing
- Values after reset: IDLE; busy=0, valid=0, overrun=0, counts=0, ovf=0, seq=0, accumulators and timer 0.
- rst overrides all other inputs, including mid-window and mid-handshake; a pending result is lost.
- enable rises in cycle t: busy=1 from t+1; the window covers cycles t+1 .. t+L.
- The result is latched in cycle t+L, so valid=1, counts and seq are updated from t+L+1.
- Latency from the last counted pulse to valid is 1 cycle.
- L=1: every RUN cycle is a terminal cycle, and counts[i] equals pulse[i] of the previous cycle.
- busy drops the cycle after an abort or after a terminal cycle with enable=0.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset then enable, with window_len=10 and ch0 pulsing on RUN cycles 1, 5 and 10 (the last one in the terminal cycle) -> valid rises 11 cycles after enable, counts[ch0]=3, other channels 0, seq=1, ovf=0.
- Continuous enable, window_len=4, a pulse on ch1 every cycle, rd_ack 1 cycle after each valid -> every window reports 4, seq increments 1,2,3,…, no lost pulses at window boundaries, and overrun stays 0.
- CW=4 build, window_len=20, a pulse every cycle on ch2 -> counts[ch2]=15, ovf[2]=1, other ovf bits 0.
- window_len=3, rd_ack never asserted -> second latch sets overrun=1 with seq=2. Then rd_ack in the same cycle as the third latch -> valid stays 1, overrun=0, seq=3.
- enable dropped on cycle 5 of a 10-cycle window after a prior result with seq=1 -> busy=0 next cycle, valid, counts and seq unchanged; re-enable starts a fresh window from 0.
- rst asserted mid-window and with valid=1 -> all outputs 0 next cycle. window_len=0 -> behaves as L=1. seq wraps 255 -> 0 after 256 windows.

Source files
------------

// File: rtl/pulse_window_sched.sv
// Measurement-window scheduler: counts per-channel pulse flags over back-to-back windows
// and presents each window's latched counts to the host through a valid/ack handshake.
module pulse_window_sched #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 16,
    parameter int unsigned TW  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [TW-1:0]     window_len,
    input  logic [NCH-1:0]    pulse,
    output logic              busy,
    output logic              valid,
    input  logic              rd_ack,
    output logic [NCH*CW-1:0] counts,
    output logic [NCH-1:0]    ovf,
    output logic              overrun,
    output logic [7:0]        seq
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              state_q;
    logic [CW-1:0]       acc_q [NCH];
    logic [NCH-1:0]      sat_q;
    logic [TW-1:0]       timer_q;
    logic                busy_q;
    logic                valid_q;
    logic                overrun_q;
    logic [NCH*CW-1:0]   counts_q;
    logic [NCH-1:0]      ovf_q;
    logic [7:0]          seq_q;

    logic [CW-1:0]       acc_nxt [NCH];
    logic [NCH-1:0]      inc_sat;
    logic [TW-1:0]       len_m1;
    logic                last;

    // Saturating increment; inc_sat marks a pulse that could not be counted.
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            inc_sat[i] = pulse[i] & (&acc_q[i]);
            acc_nxt[i] = acc_q[i] + CW'(pulse[i] & ~(&acc_q[i]));
        end
        len_m1 = (window_len == '0) ? '0 : window_len - TW'(1);
        last   = (timer_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            for (int i = 0; i < int'(NCH); i++) acc_q[i] <= '0;
            sat_q     <= '0;
            timer_q   <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            counts_q  <= '0;
            ovf_q     <= '0;
            seq_q     <= '0;
        end else begin
            if (valid_q && rd_ack) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        for (int i = 0; i < int'(NCH); i++) acc_q[i] <= '0;
                        sat_q   <= '0;
                        timer_q <= len_m1;
                    end
                end
                StRun: begin
                    if (last) begin
                        for (int i = 0; i < int'(NCH); i++) counts_q[i*CW +: CW] <= acc_nxt[i];
                        ovf_q   <= sat_q | inc_sat;
                        seq_q   <= seq_q + 8'd1;
                        valid_q <= 1'b1;
                        // An unacked result is being replaced; an ack this cycle retires
                        // the old result instead and the clear above stands.
                        if (valid_q && !rd_ack) overrun_q <= 1'b1;
                        for (int i = 0; i < int'(NCH); i++) acc_q[i] <= '0;
                        sat_q <= '0;
                        if (enable) begin
                            timer_q <= len_m1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            timer_q <= '0;
                        end
                    end else if (!enable) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        for (int i = 0; i < int'(NCH); i++) acc_q[i] <= '0;
                        sat_q   <= '0;
                        timer_q <= '0;
                    end else begin
                        for (int i = 0; i < int'(NCH); i++) acc_q[i] <= acc_nxt[i];
                        sat_q   <= sat_q | inc_sat;
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign counts  = counts_q;
    assign ovf     = ovf_q;
    assign seq     = seq_q;

endmodule

// File: tb/tb_pulse_window_sched.sv
// Randomized bench for pulse_window_sched against a window-level reference model
// (total pulses per window, clipped at the count ceiling), plus one directed window.
module tb_pulse_window_sched;

    localparam int NCH  = 4;
    localparam int CW   = 4;
    localparam int TW   = 24;
    localparam int MAXC = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst, enable, rd_ack;
    logic [TW-1:0]     window_len;
    logic [NCH-1:0]    pulse;
    logic              busy, valid, overrun;
    logic [NCH*CW-1:0] counts;
    logic [NCH-1:0]    ovf;
    logic [7:0]        seq;

    always #5 clk = ~clk;

    pulse_window_sched #(.NCH(NCH), .CW(CW), .TW(TW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .window_len(window_len), .pulse(pulse),
        .busy(busy), .valid(valid), .rd_ack(rd_ack), .counts(counts), .ovf(ovf),
        .overrun(overrun), .seq(seq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a window is L cycles long; its result is the total pulse count
    // per channel, clipped to MAXC, with ovf meaning the total exceeded MAXC.
    bit             m_run, m_valid, m_ovr;
    int             m_left, m_seq;
    int             m_tot [NCH];
    int             m_cnt [NCH];
    bit [NCH-1:0]   m_ovf;

    function automatic int eff_len(input logic [TW-1:0] wl);
        return (wl == '0) ? 1 : int'(wl);
    endfunction

    task automatic model_step();
        bit latch = 0;
        bit ack;
        if (rst) begin
            m_run = 0; m_valid = 0; m_ovr = 0; m_left = 0; m_seq = 0; m_ovf = '0;
            for (int i = 0; i < NCH; i++) begin m_tot[i] = 0; m_cnt[i] = 0; end
            return;
        end
        ack = m_valid && rd_ack;
        if (m_run) begin
            for (int i = 0; i < NCH; i++) m_tot[i] += int'(pulse[i]);
            if (m_left == 1) begin
                latch = 1;
                for (int i = 0; i < NCH; i++) begin
                    m_cnt[i] = (m_tot[i] > MAXC) ? MAXC : m_tot[i];
                    m_ovf[i] = (m_tot[i] > MAXC);
                    m_tot[i] = 0;
                end
                m_seq = (m_seq + 1) % 256;
                if (enable) m_left = eff_len(window_len);
                else m_run = 0;
            end else if (!enable) begin
                m_run = 0;
            end else begin
                m_left--;
            end
        end else if (enable) begin
            m_run  = 1;
            m_left = eff_len(window_len);
            for (int i = 0; i < NCH; i++) m_tot[i] = 0;
        end
        if (latch) begin
            m_ovr   = (m_valid && !rd_ack) ? 1'b1 : (ack ? 1'b0 : m_ovr);
            m_valid = 1;
        end else if (ack) begin
            m_valid = 0;
            m_ovr   = 0;
        end
    endtask

    task automatic check_all();
        logic [NCH*CW-1:0] exp_counts;
        for (int i = 0; i < NCH; i++) exp_counts[i*CW +: CW] = CW'(m_cnt[i]);
        check_eq("busy", busy, m_run);
        check_eq("valid", valid, m_valid);
        check_eq("overrun", overrun, m_ovr);
        check_eq("seq", seq, m_seq[7:0]);
        check_eq("counts", counts, exp_counts);
        check_eq("ovf", ovf, m_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        int wl_lo, wl_hi, dens, en_p, ack_p;
        rst = 1'b1; enable = 1'b0; window_len = '0; pulse = '0; rd_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Directed: L=10, ch0 pulses on RUN cycles 1, 5 and 10.
        enable = 1'b1; window_len = 24'd10;
        tick();
        for (int k = 1; k <= 10; k++) begin
            pulse = (k == 1 || k == 5 || k == 10) ? 4'b0001 : 4'b0000;
            if (k == 10) check_eq("dir_valid_before", valid, 1'b0);
            tick();
        end
        pulse = '0;
        check_eq("dir_valid", valid, 1'b1);
        check_eq("dir_counts", counts, 16'h0003);
        check_eq("dir_seq", seq, 8'd1);
        check_eq("dir_ovf", ovf, 4'b0000);
        enable = 1'b0; rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        tick();
        check_eq("dir_busy_after_abort", busy, 1'b0);

        // Randomized phases.
        for (int p = 0; p < 40; p++) begin
            wl_lo = $urandom_range(0, 3);
            wl_hi = wl_lo + (($urandom_range(0, 3) == 0) ? 40 : $urandom_range(0, 10));
            dens  = $urandom_range(0, 100);
            en_p  = ($urandom_range(0, 2) != 0) ? 100 : $urandom_range(60, 99);
            ack_p = $urandom_range(0, 60);
            for (int c = 0; c < 150; c++) begin
                rst        = ($urandom_range(0, 999) < 3);
                enable     = ($urandom_range(0, 99) < en_p);
                window_len = TW'($urandom_range(wl_lo, wl_hi));
                rd_ack     = ($urandom_range(0, 99) < ack_p);
                for (int i = 0; i < NCH; i++) pulse[i] = ($urandom_range(0, 99) < dens);
                tick();
            end
        end

        // Many L=1 windows so seq wraps past 255.
        rst = 1'b0; enable = 1'b1;
        for (int c = 0; c < 600; c++) begin
            window_len = TW'($urandom_range(0, 1));
            rd_ack     = $urandom_range(0, 1);
            pulse      = NCH'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
